// File: rtl/banco_registros_sb_pkg.sv
// Shared definitions for the register bank with integrated pending-write scoreboard.
// Pointer width is derived from the register count.
package banco_pkg;

  localparam int N_DEF    = 32;
  localparam int ZERO_IDX = 0;

  typedef logic [N_DEF-1:0] busy_vec_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/banco_registros_sb_scoreboard_rsv.sv
// Pending-write scoreboard: busy bits, reservation handshake, per-port busy lookup
// and an occupancy counter that tracks only real 0->1 and 1->0 transitions.
module scoreboard_rsv
  import banco_pkg::*;
#(
  parameter int N        = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int PW      = ptr_w(N),
  localparam int CW      = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] ptr_rd [NRD],
  output logic [NRD-1:0] busy_rd,
  input  logic          wr_en,
  input  logic [PW-1:0] ptr_wr,
  input  logic          rsv_en,
  input  logic [PW-1:0] ptr_rsv,
  output logic          rsv_ok,
  output logic [CW-1:0] busy_cnt
);

  logic [N-1:0] busy;
  logic [N-1:0] busy_nxt;
  logic         rsv_zero;
  logic         rsv_hit;
  logic         rsv_set;
  logic         set_t;
  logic         clr_t;

  // A same-cycle writeback to the requested register frees it, so the reservation
  // may proceed; the set is applied after the clear so the new producer wins.
  always_comb begin
    rsv_zero = ZERO_REG && (ptr_rsv == PW'(ZERO_IDX));
    rsv_hit  = wr_en && (ptr_wr == ptr_rsv);
    rsv_ok   = rsv_en && (rsv_zero || !busy[ptr_rsv] || rsv_hit);
    rsv_set  = rsv_ok && !rsv_zero;
    set_t    = rsv_set && !busy[ptr_rsv];
    clr_t    = wr_en && busy[ptr_wr] && !(rsv_set && rsv_hit);
    busy_nxt = busy;
    if (wr_en)   busy_nxt[ptr_wr]  = 1'b0;
    if (rsv_set) busy_nxt[ptr_rsv] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + CW'(set_t) - CW'(clr_t);
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_busy_rd
    assign busy_rd[p] = busy[ptr_rd[p]] && !(wr_en && (ptr_wr == ptr_rd[p]));
  end

endmodule

// File: rtl/banco_registros_sb.sv
// Multi-port register bank for the in-order integer pipeline with write-to-read
// bypass, optional hardwired x0 and an integrated RAW scoreboard.
module banco_registros_sb
  import banco_pkg::*;
#(
  parameter int N        = 32,
  parameter int Bits     = 64,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int PW      = ptr_w(N),
  localparam int CW      = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PW-1:0]   ptr_rd [NRD],
  output logic [Bits-1:0] data_rd [NRD],
  output logic [NRD-1:0]  busy_rd,
  input  logic            wr_en,
  input  logic [PW-1:0]   ptr_wr,
  input  logic [Bits-1:0] data_wr,
  input  logic            rsv_en,
  input  logic [PW-1:0]   ptr_rsv,
  output logic            rsv_ok,
  output logic [CW-1:0]   busy_cnt
);

  logic [Bits-1:0] regs [N];
  logic            wr_drop;

  assign wr_drop = ZERO_REG && (ptr_wr == PW'(ZERO_IDX));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (wr_en && !wr_drop) begin
      regs[ptr_wr] <= data_wr;
    end
  end

  // Read priority: hardwired zero, then the in-flight writeback, then storage.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [Bits-1:0] rd_val;
    always_comb begin
      if (ZERO_REG && (ptr_rd[p] == PW'(ZERO_IDX)))
        rd_val = '0;
      else if (wr_en && (ptr_wr == ptr_rd[p]))
        rd_val = data_wr;
      else
        rd_val = regs[ptr_rd[p]];
    end
    assign data_rd[p] = rd_val;
  end

  scoreboard_rsv #(
    .N        (N),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .ptr_rd   (ptr_rd),
    .busy_rd  (busy_rd),
    .wr_en    (wr_en),
    .ptr_wr   (ptr_wr),
    .rsv_en   (rsv_en),
    .ptr_rsv  (ptr_rsv),
    .rsv_ok   (rsv_ok),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_banco_registros_sb.sv
// Self-checking bench: directed scenarios plus random traffic compared against
// an array-based model of the register bank and its busy set.
module tb_banco_registros_sb;

  localparam int N    = 32;
  localparam int BITS = 64;
  localparam int NRD  = 2;
  localparam int PW   = 5;
  localparam int CW   = 6;

  logic            clk;
  logic            rst;
  logic [PW-1:0]   ptr_rd [NRD];
  logic [BITS-1:0] data_rd [NRD];
  logic [NRD-1:0]  busy_rd;
  logic            wr_en;
  logic [PW-1:0]   ptr_wr;
  logic [BITS-1:0] data_wr;
  logic            rsv_en;
  logic [PW-1:0]   ptr_rsv;
  logic            rsv_ok;
  logic [CW-1:0]   busy_cnt;

  banco_registros_sb #(
    .N        (N),
    .Bits     (BITS),
    .NRD      (NRD),
    .ZERO_REG (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ptr_rd   (ptr_rd),
    .data_rd  (data_rd),
    .busy_rd  (busy_rd),
    .wr_en    (wr_en),
    .ptr_wr   (ptr_wr),
    .data_wr  (data_wr),
    .rsv_en   (rsv_en),
    .ptr_rsv  (ptr_rsv),
    .rsv_ok   (rsv_ok),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [BITS-1:0] m_reg [N];
  bit              m_busy [N];
  bit              m_valid;
  int              n_vec;
  int              n_err;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [PW-1:0] p);
    if (p == 0) return 64'd0;
    if (wr_en && ptr_wr == p) return data_wr;
    return m_reg[p];
  endfunction

  function automatic logic m_busy_rd(input logic [PW-1:0] p);
    return m_busy[p] && !(wr_en && ptr_wr == p);
  endfunction

  function automatic logic m_rsv_ok();
    return rsv_en && (ptr_rsv == 0 || !m_busy[ptr_rsv] || (wr_en && ptr_wr == ptr_rsv));
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic drive(input logic r, input logic we, input logic [PW-1:0] pw,
                       input logic [63:0] dw, input logic re, input logic [PW-1:0] pr,
                       input logic [PW-1:0] p0, input logic [PW-1:0] p1);
    rst = r; wr_en = we; ptr_wr = pw; data_wr = dw;
    rsv_en = re; ptr_rsv = pr; ptr_rd[0] = p0; ptr_rd[1] = p1;
    #2;
    if (m_valid) begin
      for (int p = 0; p < NRD; p++) begin
        check_val($sformatf("data_rd[%0d]", p), data_rd[p], m_read(ptr_rd[p]));
        check_val($sformatf("busy_rd[%0d]", p), 64'(busy_rd[p]), 64'(m_busy_rd(ptr_rd[p])));
      end
      check_val("rsv_ok", 64'(rsv_ok), 64'(m_rsv_ok()));
      check_val("busy_cnt", 64'(busy_cnt), 64'(m_count()));
    end
  endtask

  task automatic tick();
    logic ok;
    @(posedge clk);
    ok = m_rsv_ok();
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      if (wr_en && ptr_wr != 0) m_reg[ptr_wr] = data_wr;
      if (wr_en) m_busy[ptr_wr] = 1'b0;
      if (ok && ptr_rsv != 0) m_busy[ptr_rsv] = 1'b1;
    end
    @(negedge clk);
  endtask

  function automatic logic [PW-1:0] pick();
    if ($urandom_range(0, 3) == 0) return PW'($urandom_range(0, N - 1));
    return PW'($urandom_range(0, 7));
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    m_valid = 1'b0;

    // reset overrides a same-cycle write
    drive(1'b1, 1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 5'd0, 5'd5); tick();
    drive(1'b0, 1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, 5'd0, 5'd5);
    check_val("rst_reg5", data_rd[1], 64'd0);
    check_val("rst_cnt", 64'(busy_cnt), 64'd0);
    check_val("x0_bypass", data_rd[0], 64'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_val("x0_read", data_rd[0], 64'd0);
    tick();

    // write with bypass, then storage read
    drive(1'b0, 1'b1, 5'd7, 64'h1234_5678_9ABC_DEF0, 1'b0, 5'd0, 5'd0, 5'd7);
    check_val("bypass", data_rd[1], 64'h1234_5678_9ABC_DEF0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd7);
    check_val("stored", data_rd[1], 64'h1234_5678_9ABC_DEF0);
    tick();

    // reservation and stall
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd3, 5'd0);
    check_val("rsv3_ok", 64'(rsv_ok), 64'd1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd3, 5'd0);
    check_val("rsv3_busy", 64'(busy_rd[0]), 64'd1);
    check_val("rsv3_cnt", 64'(busy_cnt), 64'd1);
    check_val("rsv3_retry", 64'(rsv_ok), 64'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3, 5'd0);
    check_val("rsv3_cnt_hold", 64'(busy_cnt), 64'd1);
    tick();

    // writeback resolves the hazard in the same cycle
    drive(1'b0, 1'b1, 5'd3, 64'h55, 1'b0, 5'd0, 5'd3, 5'd0);
    check_val("wb3_busy", 64'(busy_rd[0]), 64'd0);
    check_val("wb3_data", data_rd[0], 64'h55);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3, 5'd0);
    check_val("wb3_cnt", 64'(busy_cnt), 64'd0);
    tick();

    // simultaneous reserve and write on reg9
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd9, 5'd0); tick();
    drive(1'b0, 1'b1, 5'd9, 64'h99, 1'b1, 5'd9, 5'd9, 5'd0);
    check_val("sim9_ok", 64'(rsv_ok), 64'd1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    check_val("sim9_busy", 64'(busy_rd[0]), 64'd1);
    check_val("sim9_cnt", 64'(busy_cnt), 64'd1);
    check_val("sim9_data", data_rd[0], 64'h99);
    tick();
    drive(1'b0, 1'b1, 5'd9, 64'h77, 1'b0, 5'd0, 5'd0, 5'd0); tick();

    // fill every register, x0 reservation is a no-op
    for (int i = 1; i < N; i++) begin
      drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, PW'(i), PW'(i), 5'd0); tick();
    end
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd31, 5'd1);
    check_val("fill_cnt", 64'(busy_cnt), 64'd31);
    check_val("fill_x0_ok", 64'(rsv_ok), 64'd1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_val("fill_cnt_hold", 64'(busy_cnt), 64'd31);
    tick();

    // reset in the middle of operation
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0); tick();
    for (int i = 0; i < N / 2; i++) begin
      drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, PW'(2 * i), PW'(2 * i + 1));
      check_val("mrst_data0", data_rd[0], 64'd0);
      check_val("mrst_data1", data_rd[1], 64'd0);
      check_val("mrst_busy", 64'(busy_rd), 64'd0);
      check_val("mrst_cnt", 64'(busy_cnt), 64'd0);
      tick();
    end

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      drive(logic'($urandom_range(0, 99) == 0),
            logic'($urandom_range(0, 9) < 4), pick(), {$urandom, $urandom},
            logic'($urandom_range(0, 1)), pick(), pick(), pick());
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
